pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the five-stage pipeline fetch stage.
- Adds the following over the plain keep/update PC register:
  - configurable width, reset vector and increment
  - prioritised redirect sources: trap, branch/jump, return
  - a circular return-address stack (RAS)
  - boot delay and halt/resume FSM
- Drives IF-stage address and a fetch-valid qualifier.

Parameters:
XLEN  32  PC width in bits
RESET_VEC  32'h00000000  PC value loaded at reset
INC  4  sequential increment
RAS_DEPTH  4  return-address stack entries (power of 2, >=2)
BOOT_DELAY  2  cycles held in BOOT after reset release (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  keep PC (load-use hazard)
redirect_i  in  1  branch/jump taken
redirect_pc_i  in  XLEN  branch/jump target
trap_i  in  1  exception/interrupt entry
trap_vec_i  in  XLEN  trap target
call_i  in  1  current fetch is a call; push pc_o+INC
ret_i  in  1  current fetch is a return; pop and jump
halt_i  in  1  request halt
resume_i  in  1  leave halt
pc_o  out  XLEN  current fetch address
pc_valid_o  out  1  pc_o is a real fetch
halted_o  out  1  FSM in HALT
ras_empty_o  out  1  RAS holds no entries
ras_full_o  out  1  RAS holds RAS_DEPTH entries
misalign_o  out  1  one-cycle pulse, misaligned target seen

Behaviour:
- Reset (rst_n=0, async):
  - pc_o=RESET_VEC, pc_valid_o=0, halted_o=0, misalign_o=0
  - RAS count=0, so ras_empty_o=1 and ras_full_o=0
  - state=BOOT, boot counter=0
- BOOT:
  - counter increments each cycle; pc_o held; valid=0; all requests ignored.
  - After BOOT_DELAY cycles -> RUN. First valid fetch is RESET_VEC.
- RUN: pc_valid_o=1. Next-PC priority, highest first:
  1. trap_i -> trap_vec_i
  2. redirect_i -> redirect_pc_i
  3. ret_i with RAS non-empty -> popped top
  4. stall_i -> hold
  5. otherwise pc_o+INC, modulo 2^XLEN (wraps silently)
- RAS updates take effect on the same edge as the PC update.
- RAS push (call_i):
  - Occurs only when not stalled and no trap, so stall or trap suppresses push.
  - Call with redirect is the normal case: push pc_o+INC, jump to redirect_pc_i.
  - Push when full: overwrites oldest entry circularly; count stays RAS_DEPTH.
- RAS pop (ret_i):
  - Suppressed by trap or redirect.
  - Pop when empty: ignored; rules 4/5 apply.
- call_i and ret_i together: pop then push, replacing top; count unchanged. Next PC = old top.
- halt_i in RUN (no trap):
  - Next state HALT; pc_o keeps its computed next value, then freezes.
- HALT:
  - valid=0, halted_o=1.
  - resume_i -> RUN with pc_o unchanged.
  - trap_i -> RUN with pc_o=trap_vec_i.
  - Other inputs ignored.
- Reset mid-operation: immediate return to reset values; RAS contents discarded via count=0.
- Latency: every input registered to pc_o in exactly one cycle; no combinational input->output path.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - Any selected target from trap, redirect or RAS with bit[1:0]!=0 has bits[1:0] forced to 0.
  - misalign_o pulses high for the cycle pc_o holds the corrected value.
- Undefined:
  - Targets used verbatim.
  - misalign_o tied 0.

Test Plan:
- Reset release with BOOT_DELAY=2 -> pc_o=0, valid=0 for 2 cycles, then 0,4,8 with valid=1.
- Hold stall_i at pc_o=0x10 for 3 cycles -> pc_o stays 0x10, then 0x14.
- Simultaneous trap_i (vec 0x80), redirect_i (0x40) and stall_i at pc_o=0x20 -> pc_o=0x80 next cycle; no RAS change.
- Five calls at 0x100 (redirect 0x200), 0x204, 0x304, 0x404, 0x504 targets, with RAS_DEPTH=4, then five returns:
  - Calls: ras_full_o=1 after the 4th; the 5th overwrites 0x104.
  - Returns go to 0x508, 0x408, 0x308, 0x208.
  - ras_empty_o=1 after the 4th return; the 5th return is ignored (pc_o+4).
- halt_i at pc_o=0x30 -> halted_o=1 and valid=0 from 0x34; resume_i -> fetch 0x34, 0x38.
- PC_ALIGN_CHECK_EN defined, redirect to 0x46 -> pc_o=0x44 and misalign_o=1 for one cycle. Undefined -> pc_o=0x46, misalign_o=0.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage of a five-stage pipeline.
// Boots for BOOT_DELAY cycles, then issues sequential fetches. Next-PC priority
// is trap > redirect > RAS return > stall > PC+INC. A circular return-address
// stack records call return points, and a HALT state freezes fetch.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   stall_i         hold the PC (load-use hazard)
//   redirect_i      branch/jump taken, target redirect_pc_i
//   trap_i          exception/interrupt entry, target trap_vec_i
//   call_i          current fetch is a call; push pc_o+INC
//   ret_i           current fetch is a return; pop and jump
//   halt_i          request halt
//   resume_i        leave halt
//   pc_o            current fetch address
//   pc_valid_o      pc_o is a real fetch
//   halted_o        FSM is in HALT
//   ras_empty_o     RAS holds no entries
//   ras_full_o      RAS holds RAS_DEPTH entries
//   misalign_o      one-cycle pulse while pc_o holds a corrected target
//
// Build option: define PC_ALIGN_CHECK_EN to force bits [1:0] of trap, redirect
// and RAS targets to zero and flag the correction on misalign_o. Without it,
// targets are used verbatim and misalign_o is tied low.

module pc_gen #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_VEC  = '0,
   parameter int unsigned     INC        = 4,
   parameter int unsigned     RAS_DEPTH  = 4,
   parameter int unsigned     BOOT_DELAY = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_vec_i,
   input  logic            call_i,
   input  logic            ret_i,
   input  logic            halt_i,
   input  logic            resume_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   output logic            halted_o,
   output logic            ras_empty_o,
   output logic            ras_full_o,
   output logic            misalign_o
);

   localparam int unsigned PTR_W  = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BOOT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic [XLEN-1:0]     pc_inc;
   logic [XLEN-1:0]     tgt;
   logic                tgt_sel;

   logic [XLEN-1:0]     ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]    ras_tp_q, ras_tp_d;
   logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;
   logic [PTR_W-1:0]    ras_wr_idx;
   logic                ras_push, ras_pop;
   logic                ras_empty, ras_full;
   logic [XLEN-1:0]     ras_top;

   assign pc_inc    = pc_q + XLEN'(INC);
   assign ras_empty = (ras_cnt_q == '0);
   assign ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
   assign ras_top   = ras_mem[ras_tp_q];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         boot_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
      end
   end

   // Next-state logic: boot countdown, halt entry, resume/trap exit
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      case (state_q)
         S_BOOT: begin
            if (boot_cnt_q == BOOT_W'(BOOT_DELAY - 1)) begin
               state_d = S_RUN;
            end else begin
               boot_cnt_d = boot_cnt_q + BOOT_W'(1);
            end
         end
         S_RUN: begin
            // A simultaneous trap wins over halt and keeps us running
            if (halt_i && !trap_i) begin
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            if (trap_i || resume_i) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      pc_valid_o = 1'b0;
      halted_o   = 1'b0;
      case (state_q)
         S_RUN:   pc_valid_o = 1'b1;
         S_HALT:  halted_o   = 1'b1;
         default: ;
      endcase
   end

   // Next-PC selection and RAS request decode
`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;
`endif
   always_comb begin
      pc_d     = pc_q;
      tgt      = '0;
      tgt_sel  = 1'b0;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      case (state_q)
         S_RUN: begin
            ras_push = call_i & ~stall_i & ~trap_i;
            ras_pop  = ret_i & ~trap_i & ~redirect_i & ~ras_empty;
            if (trap_i) begin
               tgt_sel = 1'b1;
               tgt     = trap_vec_i;
            end else if (redirect_i) begin
               tgt_sel = 1'b1;
               tgt     = redirect_pc_i;
            end else if (ras_pop) begin
               tgt_sel = 1'b1;
               tgt     = ras_top;
            end else if (!stall_i) begin
               pc_d = pc_inc;
            end
         end
         S_HALT: begin
            if (trap_i) begin
               tgt_sel = 1'b1;
               tgt     = trap_vec_i;
            end
         end
         default: ;
      endcase
      if (tgt_sel) begin
`ifdef PC_ALIGN_CHECK_EN
         pc_d = {tgt[XLEN-1:2], 2'b00};
`else
         pc_d = tgt;
`endif
      end
`ifdef PC_ALIGN_CHECK_EN
      misalign_d = tgt_sel & (|tgt[1:0]);
`endif
   end

   // RAS pointer/count update; call+return replaces the top in place
   always_comb begin
      ras_tp_d   = ras_tp_q;
      ras_cnt_d  = ras_cnt_q;
      ras_wr_idx = ras_tp_q + PTR_W'(1);
      if (ras_push && ras_pop) begin
         ras_wr_idx = ras_tp_q;
      end else if (ras_push) begin
         // When full the pointer wraps onto the oldest entry
         ras_tp_d = ras_tp_q + PTR_W'(1);
         if (!ras_full) begin
            ras_cnt_d = ras_cnt_q + CNT_W'(1);
         end
      end else if (ras_pop) begin
         ras_tp_d  = ras_tp_q - PTR_W'(1);
         ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end
   end

   // PC and RAS bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_VEC;
         ras_tp_q  <= '0;
         ras_cnt_q <= '0;
      end else begin
         pc_q      <= pc_d;
         ras_tp_q  <= ras_tp_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end

   // RAS storage; contents are meaningless while count is zero
   always_ff @(posedge clk) begin
      if (ras_push) begin
         ras_mem[ras_wr_idx] <= pc_inc;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
   assign misalign_o = misalign_q;
`else
   assign misalign_o = 1'b0;
`endif

   assign pc_o        = pc_q;
   assign ras_empty_o = ras_empty;
   assign ras_full_o  = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   localparam logic N = 1'b0;
   localparam logic Y = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
   localparam logic ALIGN = 1'b1;
`else
   localparam logic ALIGN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        stall_i, redirect_i, trap_i, call_i, ret_i, halt_i, resume_i;
   logic [31:0] redirect_pc_i, trap_vec_i;
   logic [31:0] pc_o;
   logic        pc_valid_o, halted_o, ras_empty_o, ras_full_o, misalign_o;

   int n_cmp;
   int n_err;

   pc_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .trap_i        (trap_i),
      .trap_vec_i    (trap_vec_i),
      .call_i        (call_i),
      .ret_i         (ret_i),
      .halt_i        (halt_i),
      .resume_i      (resume_i),
      .pc_o          (pc_o),
      .pc_valid_o    (pc_valid_o),
      .halted_o      (halted_o),
      .ras_empty_o   (ras_empty_o),
      .ras_full_o    (ras_full_o),
      .misalign_o    (misalign_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        trap;
      logic [31:0] tvec;
      logic        call;
      logic        ret;
      logic [31:0] exp_pc;
      logic        exp_empty;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                               input logic t, input logic [31:0] tv,
                               input logic c, input logic rt,
                               input logic [31:0] ep, input logic ee);
      vec_t v;
      v.stall = s; v.redir = r; v.rpc = rp; v.trap = t; v.tvec = tv;
      v.call = c; v.ret = rt; v.exp_pc = ep; v.exp_empty = ee;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      stall_i = 1'b0; redirect_i = 1'b0; trap_i = 1'b0; call_i = 1'b0;
      ret_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0;
      redirect_pc_i = '0; trap_vec_i = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic chk_state(input string nm, input logic [31:0] pc, input logic v,
                            input logic h, input logic e, input logic f);
      chk({nm, ".pc"},    pc_o, pc);
      chk({nm, ".valid"}, 32'(pc_valid_o), 32'(v));
      chk({nm, ".halt"},  32'(halted_o), 32'(h));
      chk({nm, ".empty"}, 32'(ras_empty_o), 32'(e));
      chk({nm, ".full"},  32'(ras_full_o), 32'(f));
   endtask

   initial begin
      logic [31:0] exp_ret [4];
      logic [31:0] t;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle();

      // Reset state
      #12;
      chk_state("reset", 32'h0, N, N, Y, N);
      chk("reset.mis", 32'(misalign_o), 32'h0);
      rst_n = 1'b1;
      #1;
      chk_state("boot0", 32'h0, N, N, Y, N);

      // Boot ignores requests
      trap_i = 1'b1; trap_vec_i = 32'h80;
      tick();
      chk_state("boot1", 32'h0, N, N, Y, N);
      tick();
      chk_state("run0", 32'h0, Y, N, Y, N);
      tick();
      chk("run4", pc_o, 32'h4);
      tick();
      chk("run8", pc_o, 32'h8);

      // Table: priority, stall, RAS suppression, call+ret, wrap
      tbl[0]  = mk(N, Y, 32'h10, N, 32'h0,  N, N, 32'h10, Y);
      tbl[1]  = mk(Y, N, 32'h0,  N, 32'h0,  N, N, 32'h10, Y);
      tbl[2]  = mk(Y, N, 32'h0,  N, 32'h0,  N, N, 32'h10, Y);
      tbl[3]  = mk(Y, N, 32'h0,  N, 32'h0,  N, N, 32'h10, Y);
      tbl[4]  = mk(N, N, 32'h0,  N, 32'h0,  N, N, 32'h14, Y);
      tbl[5]  = mk(N, Y, 32'h20, N, 32'h0,  N, N, 32'h20, Y);
      tbl[6]  = mk(Y, Y, 32'h40, Y, 32'h80, N, N, 32'h80, Y);
      tbl[7]  = mk(N, N, 32'h0,  N, 32'h0,  N, N, 32'h84, Y);
      tbl[8]  = mk(N, N, 32'h0,  N, 32'h0,  N, Y, 32'h88, Y);
      tbl[9]  = mk(Y, N, 32'h0,  N, 32'h0,  N, Y, 32'h88, Y);
      tbl[10] = mk(Y, N, 32'h0,  N, 32'h0,  Y, N, 32'h88, Y);
      tbl[11] = mk(N, N, 32'h0,  Y, 32'hC0, Y, N, 32'hC0, Y);
      tbl[12] = mk(N, N, 32'h0,  N, 32'h0,  Y, N, 32'hC4, N);
      tbl[13] = mk(N, N, 32'h0,  N, 32'h0,  Y, Y, 32'hC4, N);
      tbl[14] = mk(N, N, 32'h0,  N, 32'h0,  N, Y, 32'hC8, Y);
      tbl[15] = mk(N, Y, 32'hFFFF_FFFC, N, 32'h0, N, N, 32'hFFFF_FFFC, Y);
      tbl[16] = mk(N, N, 32'h0,  N, 32'h0,  N, N, 32'h0,  Y);
      tbl[17] = mk(N, Y, 32'h30, N, 32'h0,  N, N, 32'h30, Y);
      for (int i = 0; i < NV; i++) begin
         stall_i = tbl[i].stall; redirect_i = tbl[i].redir; redirect_pc_i = tbl[i].rpc;
         trap_i = tbl[i].trap; trap_vec_i = tbl[i].tvec;
         call_i = tbl[i].call; ret_i = tbl[i].ret;
         tick();
         chk_state($sformatf("vec%0d", i), tbl[i].exp_pc, Y, N, tbl[i].exp_empty, N);
         chk($sformatf("vec%0d.mis", i), 32'(misalign_o), 32'h0);
      end

      // Halt at 0x30, ignore requests, resume
      halt_i = 1'b1;
      tick();
      chk_state("halt", 32'h34, N, Y, Y, N);
      redirect_i = 1'b1; redirect_pc_i = 32'h999; call_i = 1'b1;
      tick();
      chk_state("halt_ign", 32'h34, N, Y, Y, N);
      resume_i = 1'b1;
      tick();
      chk_state("resume", 32'h34, Y, N, Y, N);
      tick();
      chk("resume+4", pc_o, 32'h38);
      halt_i = 1'b1;
      tick();
      chk_state("halt2", 32'h3C, N, Y, Y, N);
      trap_i = 1'b1; trap_vec_i = 32'h100;
      tick();
      chk_state("halt_trap", 32'h100, Y, N, Y, N);

      // Five calls overflow the 4-deep RAS, then five returns
      for (int i = 0; i < 5; i++) begin
         t = 32'h200 + 32'h100 * 32'(i);
         call_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = t;
         tick();
         chk_state($sformatf("call%0d", i), t, Y, N, N, (i >= 3) ? Y : N);
         tick();
         chk($sformatf("callstep%0d", i), pc_o, t + 32'h4);
      end
      exp_ret[0] = 32'h508; exp_ret[1] = 32'h408; exp_ret[2] = 32'h308; exp_ret[3] = 32'h208;
      for (int i = 0; i < 4; i++) begin
         ret_i = 1'b1;
         tick();
         chk_state($sformatf("ret%0d", i), exp_ret[i], Y, N, (i == 3) ? Y : N, N);
      end
      ret_i = 1'b1;
      tick();
      chk_state("ret_empty", 32'h20C, Y, N, Y, N);

      // Misaligned redirect target
      redirect_i = 1'b1; redirect_pc_i = 32'h46;
      tick();
      chk("mis.pc", pc_o, ALIGN ? 32'h44 : 32'h46);
      chk("mis.flag", 32'(misalign_o), 32'(ALIGN));
      tick();
      chk("mis.pc+4", pc_o, ALIGN ? 32'h48 : 32'h4A);
      chk("mis.clear", 32'(misalign_o), 32'h0);

      // Asynchronous reset mid-operation with a live RAS entry
      call_i = 1'b1;
      tick();
      chk("pre_rst.empty", 32'(ras_empty_o), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("mid_rst", 32'h0, N, N, Y, N);
      #3;
      rst_n = 1'b1;
      tick();
      chk_state("mid_rst_boot", 32'h0, N, N, Y, N);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
